// File: rtl/ins_mem_pkg.sv
// Shared constants for the instruction memory: opcodes, NOP encoding and the boot program.
package ins_mem_pkg;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam int unsigned PROG_LEN = 7;
   localparam logic [31:0] PROG [0:PROG_LEN-1] = '{
      32'h0050_0093,
      32'h00A0_0113,
      32'h0020_81B3,
      32'h4020_8233,
      32'h0030_2023,
      32'h0000_2283,
      32'h0052_0463
   };

   // Words past the end of the boot program read as NOP.
   function automatic logic [31:0] rom_word(input int unsigned idx);
      if (idx < PROG_LEN) return PROG[idx[2:0]];
      return NOP;
   endfunction

endpackage

// File: rtl/ins_imm_gen.sv
// Immediate selection from a raw instruction word (I, S and B formats; zero otherwise).
module ins_imm_gen
   import ins_mem_pkg::*;
#(
   parameter int w = 32
) (
   input  logic [w-1:0] instruction,
   output logic [11:0]  imm
);

   always_comb begin
      imm = '0;
      case (instruction[6:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: imm = instruction[31:20];
         OP_STORE:  imm = {instruction[31:25], instruction[11:7]};
         // Branch offsets are kept in half-word units, bit 0 is implied.
         OP_BRANCH: imm = {instruction[31], instruction[7], instruction[30:25], instruction[11:8]};
         default:   imm = '0;
      endcase
   end

endmodule

// File: rtl/ins_mem.sv
// Instruction memory with registered fetch and field decode.
// Defining INS_MEM_LOAD_EN adds a write port (we/waddr/wdata) for loading programs.
module ins_mem
   import ins_mem_pkg::*;
#(
   parameter int w        = 32,
   parameter int d        = 128,
   parameter int pc_len   = 32,
   parameter int addr_len = 5,
   parameter int oplen    = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [pc_len-1:0]   pcaddress,
`ifdef INS_MEM_LOAD_EN
   input  logic                we,
   input  logic [pc_len-1:0]   waddr,
   input  logic [w-1:0]        wdata,
`endif
   output logic [w-1:0]        instruction,
   output logic [oplen-1:0]    op,
   output logic [addr_len-1:0] rd,
   output logic [addr_len-1:0] rs1,
   output logic [addr_len-1:0] rs2,
   output logic [2:0]          funct3,
   output logic [6:0]          funct7,
   output logic [11:0]         imm
);

   localparam int aw = $clog2(d);

   logic [aw-1:0] ridx;
   logic          rin;
   logic [w-1:0]  rom_q;
   logic [w-1:0]  word_next;
   logic [11:0]   imm_next;

   assign ridx  = pcaddress[2 +: aw];
   assign rin   = (pcaddress >> (aw + 2)) == '0;
   assign rom_q = w'(rom_word(32'(ridx)));

`ifdef INS_MEM_LOAD_EN
   // Loaded words live in a RAM overlay; a per-word flag selects it over the boot ROM.
   // The flags are not reset so that rst never disturbs memory contents.
   logic [w-1:0]  ram [d];
   logic [d-1:0]  written = '0;
   logic [aw-1:0] widx;
   logic          win;

   assign widx = waddr[2 +: aw];
   assign win  = (waddr >> (aw + 2)) == '0;

   always_ff @(posedge clk) begin
      if (we && win) begin
         ram[widx]     <= wdata;
         written[widx] <= 1'b1;
      end
   end

   assign word_next = !rin            ? w'(NOP)   :
                      written[ridx]   ? ram[ridx] : rom_q;
`else
   assign word_next = rin ? rom_q : w'(NOP);
`endif

   ins_imm_gen #(.w(w)) u_imm_gen (
      .instruction (word_next),
      .imm         (imm_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instruction <= '0;
         op          <= '0;
         rd          <= '0;
         rs1         <= '0;
         rs2         <= '0;
         funct3      <= '0;
         funct7      <= '0;
         imm         <= '0;
      end else begin
         instruction <= word_next;
         op          <= word_next[oplen-1:0];
         rd          <= word_next[7 +: addr_len];
         rs1         <= word_next[15 +: addr_len];
         rs2         <= word_next[20 +: addr_len];
         funct3      <= word_next[14:12];
         funct7      <= word_next[31:25];
         imm         <= imm_next;
      end
   end

endmodule

// File: tb/tb_ins_mem.sv
// Directed self-checking bench for ins_mem with hand-computed decode tables.
module tb_ins_mem;

   logic        clk;
   logic        rst;
   logic [31:0] pcaddress;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [31:0] instruction;
   logic [6:0]  op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [11:0] imm;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] ins;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [11:0] imm;
   } exp_t;

   //                 ins            op     rd  rs1 rs2 f3 f7     imm
   exp_t tab [0:7] = '{
      '{32'h00500093, 7'h13, 1,  0,  5,  0, 7'h00, 12'h005},
      '{32'h00A00113, 7'h13, 2,  0,  10, 0, 7'h00, 12'h00A},
      '{32'h002081B3, 7'h33, 3,  1,  2,  0, 7'h00, 12'h000},
      '{32'h40208233, 7'h33, 4,  1,  2,  0, 7'h20, 12'h000},
      '{32'h00302023, 7'h23, 0,  0,  3,  2, 7'h00, 12'h000},
      '{32'h00002283, 7'h03, 5,  0,  0,  2, 7'h00, 12'h000},
      '{32'h00520463, 7'h63, 8,  4,  5,  0, 7'h00, 12'h004},
      '{32'h00000013, 7'h13, 0,  0,  0,  0, 7'h00, 12'h000}
   };

   exp_t zero_e = '{32'h0, 7'h0, 0, 0, 0, 0, 7'h0, 12'h0};

   ins_mem dut (
      .clk         (clk),
      .rst         (rst),
      .pcaddress   (pcaddress),
`ifdef INS_MEM_LOAD_EN
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
`endif
      .instruction (instruction),
      .op          (op),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .funct3      (funct3),
      .funct7      (funct7),
      .imm         (imm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".instruction"}, instruction, e.ins);
      chk({tag, ".op"},          32'(op),     32'(e.op));
      chk({tag, ".rd"},          32'(rd),     32'(e.rd));
      chk({tag, ".rs1"},         32'(rs1),    32'(e.rs1));
      chk({tag, ".rs2"},         32'(rs2),    32'(e.rs2));
      chk({tag, ".funct3"},      32'(funct3), 32'(e.f3));
      chk({tag, ".funct7"},      32'(funct7), 32'(e.f7));
      chk({tag, ".imm"},         32'(imm),    32'(e.imm));
   endtask

   task automatic fetch(input logic [31:0] pc);
      @(negedge clk);
      pcaddress = pc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      pcaddress = 32'd0;
      we        = 1'b0;
      waddr     = 32'd0;
      wdata     = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", zero_e);

      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_all("first_after_reset", tab[0]);

      fetch(32'd12);
      chk_all("rtype_pc12", tab[3]);

      // Asynchronous reset mid-cycle, then recovery shows memory is intact.
      #2 rst = 1'b1;
      #1;
      chk("async_rst.instruction", instruction, 32'h0);
      chk("async_rst.imm", 32'(imm), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_all("after_async_rst_pc12", tab[3]);

      fetch(32'd16);
      chk_all("stype_pc16", tab[4]);
      fetch(32'd24);
      chk_all("btype_pc24", tab[6]);

      fetch(32'd9);
      chk_all("unaligned_pc9", tab[2]);
      fetch(32'd512);
      chk_all("out_of_range_512", tab[7]);
      fetch(32'hFFFF_FFFC);
      chk_all("out_of_range_top", tab[7]);
      fetch(32'd508);
      chk_all("last_word_508", tab[7]);

      for (int i = 0; i < 16; i++) begin
         fetch(32'(4 * i));
         chk_all($sformatf("sweep_w%0d", i), tab[(i < 7) ? i : 7]);
      end

`ifdef INS_MEM_LOAD_EN
      // Write and read the same word in one cycle: read sees the old word.
      @(negedge clk);
      we        = 1'b1;
      waddr     = 32'd28;
      wdata     = 32'hFFF0_0093;
      pcaddress = 32'd28;
      @(posedge clk);
      #1;
      chk("load_same_cycle.instruction", instruction, 32'h0000_0013);
      @(negedge clk);
      we = 1'b0;
      fetch(32'd28);
      chk_all("load_readback_pc28",
              '{32'hFFF00093, 7'h13, 1, 0, 31, 0, 7'h7F, 12'hFFF});

      @(negedge clk);
      we    = 1'b1;
      waddr = 32'd512;
      wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      we = 1'b0;
      fetch(32'd0);
      chk_all("oor_write_no_alias_pc0", tab[0]);
      fetch(32'd512);
      chk_all("oor_write_read_512", tab[7]);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ins_mem.md
INS_MEM -- requirements
Module: ins_mem

Interface
REQ-001 SHALL have parameter w, default 32, instruction word width.
REQ-002 SHALL have parameter d, default 128, memory depth in words (power of two).
REQ-003 SHALL have parameter pc_len, default 32, program-counter width.
REQ-004 SHALL have parameter addr_len, default 5, register-index width.
REQ-005 SHALL have parameter oplen, default 7, opcode width.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (async active-high reset).
REQ-007 SHALL have port pcaddress, input, pc_len bits: byte address of the instruction.
REQ-008 SHALL have port instruction, output, w bits: fetched word.
REQ-009 SHALL have port op, output, oplen bits: instruction[6:0].
REQ-010 SHALL have ports rd, rs1 and rs2, output, addr_len bits each: instruction[11:7], [19:15] and [24:20].
REQ-011 SHALL have ports funct3 (output, 3 bits, instruction[14:12]) and funct7 (output, 7 bits, instruction[31:25]).
REQ-012 SHALL have port imm, output, 12 bits: decoded immediate.

Function
REQ-013 SHALL index the word array with pcaddress[2 +: log2(d)] and ignore pcaddress[1:0].
REQ-014 SHALL return NOP 0x00000013 for any pcaddress >= 4*d.
REQ-015 SHALL register all outputs on the rising edge of clk, giving 1-cycle latency from pcaddress to outputs.
REQ-016 SHALL drive rd, rs1, rs2, funct3 and funct7 as raw slices for every opcode.
REQ-017 SHALL decode imm for I-type (op 0x03, 0x13, 0x67, 0x73) as instruction[31:20].
REQ-018 SHALL decode imm for S-type (op 0x23) as {instruction[31:25], instruction[11:7]}.
REQ-019 SHALL decode imm for B-type (op 0x63) as {instruction[31], instruction[7], instruction[30:25], instruction[11:8]}, i.e. byte offset/2.
REQ-020 SHALL output imm = 0 for all other opcodes (R, U, J, unknown).
REQ-021 SHALL hold this default program, with all other words 0x00000013:
- word0 = 0x00500093
- word1 = 0x00A00113
- word2 = 0x002081B3
- word3 = 0x40208233
- word4 = 0x00302023
- word5 = 0x00002283
- word6 = 0x00520463

Reset
REQ-022 SHALL clear instruction, op, rd, rs1, rs2, funct3, funct7 and imm to 0 immediately on rst assertion.
REQ-023 SHALL leave memory contents unaffected by rst.
REQ-024 SHALL present the word at the current pcaddress at the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL add, when INS_MEM_LOAD_EN is defined, input ports we (1 bit), waddr (pc_len bits, byte address) and wdata (w bits).
REQ-026 SHALL, with INS_MEM_LOAD_EN defined, write wdata to the word at waddr on the rising edge of clk while we=1.
REQ-027 SHALL, with INS_MEM_LOAD_EN defined, ignore writes to out-of-range addresses.
REQ-028 SHALL, with INS_MEM_LOAD_EN defined, return the old data for a read and write to the same word in the same cycle.
REQ-029 SHALL, without INS_MEM_LOAD_EN, have no write ports and be a pure ROM holding the default program.

Structure
REQ-030 SHALL place in package ins_mem_pkg:
- opcode constants (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JALR, OP_SYSTEM)
- NOP constant 0x00000013
- the default program array
REQ-031 SHALL place immediate selection in one sub-module, ins_imm_gen, with inputs instruction and outputs imm.

Verification
REQ-032 SHALL check reset: assert rst with pcaddress=0 -> all outputs 0; release rst, one clk later instruction=0x00500093, op=0x13, rd=1, rs1=0, funct3=0, imm=0x005.
REQ-033 SHALL check R-type: pcaddress=12 -> instruction=0x40208233, op=0x33, rd=4, rs1=1, rs2=2, funct7=0x20, imm=0.
REQ-034 SHALL check S/B-type decode:
- pcaddress=16 -> op=0x23, rs2=3, funct3=2, imm=0.
- pcaddress=24 -> op=0x63, rs1=4, rs2=5, imm=0x004.
REQ-035 SHALL check alignment and range:
- pcaddress=9 -> same outputs as pcaddress=8 (0x002081B3).
- pcaddress=512 -> instruction=0x00000013.
REQ-036 SHALL check a sweep: pcaddress 0 to 60 step 4, one step per clk -> outputs match REQ-021 with 1-cycle lag; words 7-15 give 0x00000013.
REQ-037 SHALL check the load port (INS_MEM_LOAD_EN only): write 0xFFF00093 at waddr=28, then read pcaddress=28 -> instruction=0xFFF00093, imm=0xFFF.
